// File: rtl/pio_edge_capture_pkg.sv
// Shared constants for the edge-capture PIO: bus address width and register map.
package pio_edge_capture_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP  = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_DEB_LIMIT = 3'd5;

endpackage

// File: rtl/pio_input_filter.sv
// One input bit: synchroniser chain, optional debounce (PIO_EDGE_CAPTURE_DEBOUNCE_EN),
// and the filtered value with its one-cycle-delayed copy for edge detection.
module pio_input_filter #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_bit,
    input  logic [DEBOUNCE_CNT_W-1:0] deb_limit,
    output logic                      filt,
    output logic                      filt_d
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in_bit};
        end
    end

`ifdef PIO_EDGE_CAPTURE_DEBOUNCE_EN
    logic [DEBOUNCE_CNT_W-1:0] cnt;

    // A new level must be seen on s for deb_limit+1 consecutive cycles before it is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (s != filt) begin
            if (cnt == deb_limit) begin
                filt <= s;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    logic deb_limit_unused;
    assign deb_limit_unused = ^deb_limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= 1'b0;
        end else begin
            filt <= s;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d <= 1'b0;
        end else begin
            filt_d <= filt;
        end
    end

endmodule

// File: rtl/pio_edge_capture_ip.sv
// Avalon-MM input PIO with per-bit rise/fall edge capture, W1C clear and level irq.
// Debounce filtering and the DEB_LIMIT register exist only with PIO_EDGE_CAPTURE_DEBOUNCE_EN.
module pio_edge_capture_ip
    import pio_edge_capture_pkg::*;
#(
    parameter int WIDTH            = 8,
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CNT_W   = 16,
    parameter int DEBOUNCE_DEFAULT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    localparam logic [DEBOUNCE_CNT_W-1:0] DEB_RST = DEBOUNCE_CNT_W'(DEBOUNCE_DEFAULT);

    logic                      wr_en;
    logic [WIDTH-1:0]          wdata;
    logic [WIDTH-1:0]          rise_en;
    logic [WIDTH-1:0]          fall_en;
    logic [WIDTH-1:0]          irq_mask;
    logic [WIDTH-1:0]          edge_cap;
    logic [WIDTH-1:0]          filt;
    logic [WIDTH-1:0]          filt_d;
    logic [WIDTH-1:0]          ev;
    logic [WIDTH-1:0]          cap_clr;
    logic [DEBOUNCE_CNT_W-1:0] deb_limit;
    logic [31:0]               rd_mux;
    logic                      writedata_unused;

    assign wr_en            = chipselect & ~write_n;
    assign wdata            = writedata[WIDTH-1:0];
    assign writedata_unused = ^{writedata, DEB_RST};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_input_filter #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_CNT_W(DEBOUNCE_CNT_W)
        ) u_filter (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_bit   (in_port[i]),
            .deb_limit(deb_limit),
            .filt     (filt[i]),
            .filt_d   (filt_d[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en  <= '0;
            fall_en  <= '0;
            irq_mask <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_RISE_EN:  rise_en  <= wdata;
                ADDR_IRQ_MASK: irq_mask <= wdata;
                ADDR_FALL_EN:  fall_en  <= wdata;
                default: ;
            endcase
        end
    end

`ifdef PIO_EDGE_CAPTURE_DEBOUNCE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_limit <= DEB_RST;
        end else if (wr_en && address == ADDR_DEB_LIMIT) begin
            deb_limit <= writedata[DEBOUNCE_CNT_W-1:0];
        end
    end
`else
    assign deb_limit = '0;
`endif

    // Set has priority over the W1C clear so an edge landing on the clear cycle is kept.
    assign ev      = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);
    assign cap_clr = (wr_en && address == ADDR_EDGE_CAP) ? wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= ev | (edge_cap & ~cap_clr);
        end
    end

    assign irq = |(edge_cap & irq_mask);

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:      rd_mux[WIDTH-1:0] = filt;
            ADDR_RISE_EN:   rd_mux[WIDTH-1:0] = rise_en;
            ADDR_IRQ_MASK:  rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP:  rd_mux[WIDTH-1:0] = edge_cap;
            ADDR_FALL_EN:   rd_mux[WIDTH-1:0] = fall_en;
`ifdef PIO_EDGE_CAPTURE_DEBOUNCE_EN
            ADDR_DEB_LIMIT: rd_mux[DEBOUNCE_CNT_W-1:0] = deb_limit;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule
